// File: rtl/axi_stream_mux_arbiter_pkg.sv
// Shared types and helpers for the packet-aware AXI-stream mux arbiter.
package axi_stream_mux_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, SWITCH} arb_state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

    // Stall counter width for a given limit; it counts 0 .. cycles-1.
    function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/axi_stream_mux_arbiter_if.sv
// Arbiter <-> mux control bundle: per-input handshake observation plus the mux select.
interface axi_stream_mux_arbiter_if #(
    parameter int unsigned N_INPUTS   = 7,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic [N_INPUTS-1:0]   in_valid;
    logic [N_INPUTS-1:0]   in_ready;
    logic [N_INPUTS-1:0]   in_tlast;
    logic [N_INPUTS-1:0]   enable_mask;
    logic [ADDR_WIDTH-1:0] address;
    logic                  grant_active;
    logic                  timeout_error;

    modport master (
        input  in_valid, in_ready, in_tlast, enable_mask,
        output address, grant_active, timeout_error
    );

    modport slave (
        output in_valid, in_ready, in_tlast, enable_mask,
        input  address, grant_active, timeout_error
    );
endinterface

// File: rtl/axi_stream_mux_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set bit of req after last_grant, wrapping,
// with last_grant itself checked last.
module rr_priority_picker #(
    parameter int unsigned N_INPUTS   = 7,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic [N_INPUTS-1:0]   req,
    input  logic [ADDR_WIDTH-1:0] last_grant,
    output logic [ADDR_WIDTH-1:0] winner,
    output logic                  found
);

    always_comb begin
        int unsigned pos;
        pos    = 0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned off = 1; off <= N_INPUTS; off++) begin
            pos = 32'(last_grant) + off;
            if (pos >= N_INPUTS) begin
                pos = pos - N_INPUTS;
            end
            if (!found && ((req >> pos) & N_INPUTS'(1)) != '0) begin
                winner = ADDR_WIDTH'(pos);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_stream_mux_arbiter.sv
// Packet-aware round-robin arbiter driving the select of a registered AXI-stream mux.
// Optional stall watchdog: define AXI_STREAM_MUX_ARBITER_TIMEOUT_EN.
module axi_stream_mux_arbiter
    import axi_stream_mux_arbiter_pkg::*;
#(
    parameter int unsigned N_INPUTS       = 7,
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    axi_stream_mux_arbiter_if.master  bus
);

    if (N_INPUTS < 2 || N_INPUTS > 8) begin : g_bad_n_inputs
        $error("N_INPUTS must be in 2..8");
    end
    if ((1 << ADDR_WIDTH) < N_INPUTS) begin : g_bad_addr_width
        $error("ADDR_WIDTH too narrow for N_INPUTS");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [ADDR_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] winner;
    logic                  grant_q, grant_d;
    logic                  found;
    logic [N_INPUTS-1:0]   req;
    logic [N_INPUTS-1:0]   sel;
    logic                  sel_hs;
    logic                  eop;
    logic                  timeout_hit;
    logic                  release_grant;

    assign req = bus.in_valid & bus.enable_mask;

    // One-hot of the granted input; shifting avoids out-of-range selects when N_INPUTS < 2**ADDR_WIDTH.
    assign sel    = N_INPUTS'(1) << address_q;
    assign sel_hs = |(bus.in_valid & bus.in_ready & sel);
    assign eop    = |(bus.in_valid & bus.in_ready & bus.in_tlast & sel);

    assign release_grant = (state_q == GRANT) && (eop || timeout_hit);

    rr_priority_picker #(
        .N_INPUTS   (N_INPUTS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (winner),
        .found      (found)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= ADDR_WIDTH'(N_INPUTS - 1);
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found) state_d = GRANT;
            GRANT:   if (release_grant) state_d = SWITCH;
            SWITCH:  state_d = found ? GRANT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SWITCH arbitrates like IDLE; it only exists because address must hold for one drain cycle.
    always_comb begin
        address_d    = address_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE, SWITCH: begin
                if (found) begin
                    address_d = winner;
                    grant_d   = 1'b1;
                end else begin
                    grant_d   = 1'b0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    last_grant_d = address_q;
                    grant_d      = 1'b0;
                end
            end
            default: grant_d = 1'b0;
        endcase
    end

`ifdef AXI_STREAM_MUX_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] stall_cnt;
    logic             timeout_q;

    assign timeout_hit = (state_q == GRANT) && !sel_hs &&
                         (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state_q != GRANT || sel_hs || timeout_hit) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign bus.timeout_error = timeout_q;
`else
    assign timeout_hit       = 1'b0;
    assign bus.timeout_error = 1'b0;
`endif

    assign bus.address      = address_q;
    assign bus.grant_active = grant_q;

endmodule

// File: tb/tb_axi_stream_mux_arbiter.sv
// Randomized and directed bench for axi_stream_mux_arbiter against a per-packet ownership model.
module tb_axi_stream_mux_arbiter;

    localparam int unsigned N  = 7;
    localparam int unsigned AW = 3;
    localparam int unsigned TO = 16;
`ifdef AXI_STREAM_MUX_ARBITER_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    axi_stream_mux_arbiter_if #(.N_INPUTS(N), .ADDR_WIDTH(AW)) bus ();

    axi_stream_mux_arbiter #(
        .N_INPUTS       (N),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: who owns the mux (-1 = nobody), who owned it last, and the expected registered outputs.
    int m_owner;
    int m_last;
    int m_stall;
    int m_addr;
    bit m_ga;
    bit m_to;
    int beats [N];

    int starts[$];
    bit prev_ga;
    int to_pulses;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic release_owner(input bit by_timeout);
        m_last  = m_owner;
        m_owner = -1;
        m_ga    = 1'b0;
        m_to    = by_timeout;
    endtask

    task automatic model_step();
        if (reset) begin
            m_owner = -1;
            m_last  = N - 1;
            m_stall = 0;
            m_addr  = 0;
            m_ga    = 1'b0;
            m_to    = 1'b0;
            foreach (beats[i]) beats[i] = 0;
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                if (bit_of(bus.in_valid, m_owner) && bit_of(bus.in_ready, m_owner)) begin
                    m_stall = 0;
                    if (bit_of(bus.in_tlast, m_owner)) begin
                        beats[m_owner] = 0;
                        release_owner(1'b0);
                    end else begin
                        beats[m_owner]++;
                    end
                end else begin
                    m_stall++;
                    if (TO_ON && m_stall == TO) release_owner(1'b1);
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (m_owner < 0 && bit_of(bus.in_valid & bus.enable_mask, c)) begin
                        m_owner = c;
                        m_addr  = c;
                        m_ga    = 1'b1;
                        m_stall = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_eq("address", int'(bus.address), m_addr);
        check_eq("grant_active", int'(bus.grant_active), int'(m_ga));
        check_eq("timeout_error", int'(bus.timeout_error), int'(m_to));
        if (bus.grant_active && !prev_ga) starts.push_back(int'(bus.address));
        if (bus.timeout_error) to_pulses++;
        prev_ga = bus.grant_active;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] r,
                         input logic [N-1:0] l, input logic [N-1:0] m);
        bus.in_valid    = v;
        bus.in_ready    = r;
        bus.in_tlast    = l;
        bus.enable_mask = m;
    endtask

    function automatic logic [N-1:0] tlast_for_len(input int len);
        logic [N-1:0] t;
        t = '0;
        for (int i = 0; i < N; i++) if (beats[i] == len - 1) t = t | (N'(1) << i);
        return t;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        drive('0, '0, '0, '1);
        tick();
        tick();
        reset = 1'b0;
        starts.delete();
        to_pulses = 0;
    endtask

    initial begin
        int hits3;
        reset = 1'b1;
        prev_ga = 1'b0;
        to_pulses = 0;
        drive('0, '0, '0, '1);

        // Reset then idle.
        do_reset();
        check_eq("reset_address", int'(bus.address), 0);
        check_eq("reset_grant", int'(bus.grant_active), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle_address", int'(bus.address), 0);
            check_eq("idle_grant", int'(bus.grant_active), 0);
        end

        // Two requesters, 3-beat packets: 0, 2, 0, 2.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(7'b0000101, '1, tlast_for_len(3), '1);
            tick();
        end
        check_eq("s2_count", starts.size(), 4);
        for (int i = 0; i < 4 && i < starts.size(); i++)
            check_eq("s2_order", starts[i], (i % 2 == 0) ? 0 : 2);

        // All requesting, single-beat packets: wrap 0..6,0.
        do_reset();
        drive('1, '1, '1, '1);
        for (int i = 0; i < 16; i++) tick();
        check_eq("s3_count", starts.size(), 8);
        for (int i = 0; i < 8 && i < starts.size(); i++)
            check_eq("s3_order", starts[i], i % N);

        // Mask cleared mid-packet on granted input 3.
        do_reset();
        drive(7'b0001000, '1, '0, '1);
        tick();
        check_eq("s4_grant3", int'(bus.address), 3);
        drive('1, '1, '0, 7'b1110111);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("s4_hold_addr", int'(bus.address), 3);
            check_eq("s4_hold_grant", int'(bus.grant_active), 1);
        end
        drive('1, '1, 7'b0001000, 7'b1110111);
        tick();
        check_eq("s4_release", int'(bus.grant_active), 0);
        starts.delete();
        drive('1, '1, '1, 7'b1110111);
        for (int i = 0; i < 20; i++) tick();
        hits3 = 0;
        foreach (starts[i]) if (starts[i] == 3) hits3++;
        check_eq("s4_no_regrant", hits3, 0);
        check_eq("s4_count", starts.size(), 10);

        // Reset coinciding with an eop on input 2.
        do_reset();
        drive(7'b0000100, '1, '0, '1);
        for (int i = 0; i < 3; i++) tick();
        check_eq("s5_grant2", int'(bus.address), 2);
        drive(7'b0000100, '1, 7'b0000100, '1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("s5_rst_addr", int'(bus.address), 0);
        check_eq("s5_rst_grant", int'(bus.grant_active), 0);
        starts.delete();
        drive(7'b1000001, '1, '0, '1);
        tick();
        check_eq("s5_first", (starts.size() > 0) ? starts[0] : -1, 0);

`ifdef AXI_STREAM_MUX_ARBITER_TIMEOUT_EN
        // Stalled packet on input 4 is forcibly released after TO cycles.
        do_reset();
        drive(7'b0110000, '0, '0, '1);
        for (int i = 0; i < 20; i++) tick();
        check_eq("s6_pulses", to_pulses, 1);
        check_eq("s6_count", starts.size(), 2);
        if (starts.size() >= 2) begin
            check_eq("s6_first", starts[0], 4);
            check_eq("s6_next", starts[1], 5);
        end
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive(N'($urandom), N'($urandom | $urandom), N'($urandom & $urandom),
                  N'($urandom | $urandom));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
